cache_evict_wb: RTL and testbench

Eviction/writeback engine at the consuming end of cache victim selection. Takes the one-hot victim way chosen by the replacement policy, together with the set, tag, dirty bit and line data of that way. Writes dirty lines to the bus beat-by-beat with a valid/ready handshake and waits for the write response. Then pulses a per-way clear-valid back into the cache tag/valid arrays. Sits between the cache controller FSM and the bus write channel.

---
 rtl/cache_evict_wb_pkg.sv | 22 ++
 rtl/evict_linebuf.sv | 52 +++++
 rtl/cache_evict_wb.sv | 147 ++++++++++++++
 tb/tb_cache_evict_wb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_evict_wb_pkg.sv
// Shared definitions for the cache eviction/writeback engine.
//   - line geometry (line width, bus beat width, byte-offset bits)
//   - derived beat count and beat-counter width
//   - FSM state type
package cache_evict_wb_pkg;

    localparam int unsigned LINELEN    = 512;
    localparam int unsigned BEATLEN    = 64;
    localparam int unsigned OFFSETLEN  = 6;
    localparam int unsigned NBEATS     = LINELEN / BEATLEN;
    // A one-beat line still needs a 1-bit counter so the mux index is well formed.
    localparam int unsigned BEATCNTLEN = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StCapture,
        StWrite,
        StResp,
        StDone
    } evict_state_e;

endpackage

// File: rtl/evict_linebuf.sv
// Victim line buffer with beat sequencer.
//   clk, reset  : clock, asynchronous active-low reset
//   load        : capture line_data into the buffer
//   line_data   : full victim line from the data array
//   advance     : current beat accepted, step to the next one
//   clear       : return the beat counter to 0
//   beat        : current beat (beat 0 = line LSBs)
//   last        : current beat is the final one of the line
module evict_linebuf
    import cache_evict_wb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [LINELEN-1:0] line_data,
    input  logic               advance,
    input  logic               clear,
    output logic [BEATLEN-1:0] beat,
    output logic               last
);

    logic [LINELEN-1:0]    line_q, line_d;
    logic [BEATCNTLEN-1:0] cnt_q, cnt_d;

    assign last = (cnt_q == BEATCNTLEN'(NBEATS - 1));
    assign beat = line_q[int'(cnt_q) * BEATLEN +: BEATLEN];

    always_comb begin
        line_d = line_q;
        cnt_d  = cnt_q;
        if (load) begin
            line_d = line_data;
        end
        if (clear) begin
            cnt_d = '0;
        end else if (advance && !last) begin
            // Counter parks on the final beat; the FSM leaves WRITE on that acceptance.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_q <= '0;
            cnt_q  <= '0;
        end else begin
            line_q <= line_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_evict_wb.sv
// Cache eviction/writeback engine.
// Accepts a victim (way, set, tag, dirty) from the cache controller, captures the
// line the cycle after, bursts dirty lines onto the bus write channel beat by beat,
// waits for the write response, then pulses a clear-valid strobe for the victim way.
//   clk, reset                      : clock, asynchronous active-low reset
//   EvictReq/Victim*/LineRdData     : request side from the cache controller
//   EvictBusy/EvictDone/EvictErr    : status back to the controller
//   ClearValidWay/ClearValidSet     : one-cycle clear-valid strobe to tag/valid arrays
//   BusAdr/BusW*/BusB*              : bus write data and response channels
module cache_evict_wb
    import cache_evict_wb_pkg::*;
#(
    parameter int unsigned NUMWAYS = 4,
    parameter int unsigned SETLEN  = 7,
    parameter int unsigned TAGLEN  = 19,
    localparam int unsigned PA_BITS = TAGLEN + SETLEN + OFFSETLEN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               EvictReq,
    input  logic [NUMWAYS-1:0] VictimWay,
    input  logic               VictimDirty,
    input  logic [TAGLEN-1:0]  VictimTag,
    input  logic [SETLEN-1:0]  VictimSet,
    input  logic [LINELEN-1:0] LineRdData,
    output logic               EvictBusy,
    output logic               EvictDone,
    output logic               EvictErr,
    output logic [NUMWAYS-1:0] ClearValidWay,
    output logic [SETLEN-1:0]  ClearValidSet,
    output logic [PA_BITS-1:0] BusAdr,
    output logic [BEATLEN-1:0] BusWData,
    output logic               BusWValid,
    output logic               BusWLast,
    input  logic               BusWReady,
    input  logic               BusBValid,
    input  logic               BusBErr
);

    evict_state_e       state_q, state_d;
    logic [NUMWAYS-1:0] way_q, way_d;
    logic [SETLEN-1:0]  set_q, set_d;
    logic [TAGLEN-1:0]  tag_q, tag_d;
    logic               dirty_q, dirty_d;
    logic               err_q, err_d;

    logic               buf_load;
    logic               buf_advance;
    logic               buf_clear;
    logic [BEATLEN-1:0] buf_beat;
    logic               buf_last;

    evict_linebuf u_linebuf (
        .clk       (clk),
        .reset     (reset),
        .load      (buf_load),
        .line_data (LineRdData),
        .advance   (buf_advance),
        .clear     (buf_clear),
        .beat      (buf_beat),
        .last      (buf_last)
    );

    // Next-state and buffer control.
    always_comb begin
        state_d     = state_q;
        way_d       = way_q;
        set_d       = set_q;
        tag_d       = tag_q;
        dirty_d     = dirty_q;
        err_d       = err_q;
        buf_load    = 1'b0;
        buf_advance = 1'b0;
        buf_clear   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (EvictReq) begin
                    way_d   = VictimWay;
                    set_d   = VictimSet;
                    tag_d   = VictimTag;
                    dirty_d = VictimDirty;
                    err_d   = 1'b0;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                buf_load = 1'b1;
                state_d  = dirty_q ? StWrite : StDone;
            end
            StWrite: begin
                if (BusWReady) begin
                    buf_advance = 1'b1;
                    if (buf_last) begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (BusBValid) begin
                    err_d   = BusBErr;
                    state_d = StDone;
                end
            end
            StDone: begin
                buf_clear = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode straight from registered state so they are glitch-free per cycle.
    always_comb begin
        EvictBusy     = (state_q != StIdle);
        EvictDone     = (state_q == StDone);
        EvictErr      = (state_q == StDone) && err_q;
        // A failed writeback leaves the line valid so the dirty data is not lost.
        ClearValidWay = ((state_q == StDone) && !err_q) ? way_q : '0;
        ClearValidSet = (state_q == StDone) ? set_q : '0;
        BusAdr        = {tag_q, set_q, {OFFSETLEN{1'b0}}};
        BusWValid     = (state_q == StWrite);
        BusWData      = (state_q == StWrite) ? buf_beat : '0;
        BusWLast      = (state_q == StWrite) && buf_last;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            way_q   <= '0;
            set_q   <= '0;
            tag_q   <= '0;
            dirty_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            way_q   <= way_d;
            set_q   <= set_d;
            tag_q   <= tag_d;
            dirty_q <= dirty_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_cache_evict_wb.sv
// Self-checking bench for cache_evict_wb: directed table, hand-written reset
// sequence, then randomized evictions against a transaction-level model.
module tb_cache_evict_wb;

    logic         clk = 1'b0;
    logic         reset;
    logic         EvictReq;
    logic [3:0]   VictimWay;
    logic         VictimDirty;
    logic [18:0]  VictimTag;
    logic [6:0]   VictimSet;
    logic [511:0] LineRdData;
    logic         EvictBusy, EvictDone, EvictErr;
    logic [3:0]   ClearValidWay;
    logic [6:0]   ClearValidSet;
    logic [31:0]  BusAdr;
    logic [63:0]  BusWData;
    logic         BusWValid, BusWLast;
    logic         BusWReady, BusBValid, BusBErr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_evict_wb dut (
        .clk           (clk),
        .reset         (reset),
        .EvictReq      (EvictReq),
        .VictimWay     (VictimWay),
        .VictimDirty   (VictimDirty),
        .VictimTag     (VictimTag),
        .VictimSet     (VictimSet),
        .LineRdData    (LineRdData),
        .EvictBusy     (EvictBusy),
        .EvictDone     (EvictDone),
        .EvictErr      (EvictErr),
        .ClearValidWay (ClearValidWay),
        .ClearValidSet (ClearValidSet),
        .BusAdr        (BusAdr),
        .BusWData      (BusWData),
        .BusWValid     (BusWValid),
        .BusWLast      (BusWLast),
        .BusWReady     (BusWReady),
        .BusBValid     (BusBValid),
        .BusBErr       (BusBErr)
    );

    // rdy_mode: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random
    typedef struct {
        logic [3:0]   way;
        logic [6:0]   set;
        logic [18:0]  tag;
        logic         dirty;
        logic         err;
        int           rdy_mode;
        int           resp_delay;
        bit           spurious;
        logic [511:0] line;
        logic [3:0]   exp_clr;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] way, input logic [6:0] set,
                                input logic [18:0] tag, input logic dirty, input logic err,
                                input int mode, input int delay, input bit spur,
                                input logic [3:0] exp_clr, input logic exp_err,
                                input int lat);
        vec_t v;
        v.way = way; v.set = set; v.tag = tag; v.dirty = dirty; v.err = err;
        v.rdy_mode = mode; v.resp_delay = delay; v.spurious = spur;
        v.exp_clr = exp_clr; v.exp_err = exp_err; v.exp_lat = lat;
        for (int i = 0; i < 8; i++) v.line[64*i +: 64] = 64'h1111_0000 + 64'(i);
        return v;
    endfunction

    // Transaction-level model: the expected beat stream is the line split into
    // 64-bit words, LSB word first; address is {tag,set,6'b0}; completion comes
    // two cycles after the request for clean lines, and one cycle after the
    // write response for dirty ones.
    task automatic run_evict(input vec_t v, input string tag_name);
        logic [63:0] exp_q[$];
        logic [31:0] exp_adr;
        int          cyc, wcyc, rcyc;
        bit          responded;
        logic [3:0]  pat;
        pat     = 4'b1001;
        exp_adr = {v.tag, v.set, 6'b0};
        if (v.dirty) begin
            for (int i = 0; i < 8; i++) exp_q.push_back(v.line[64*i +: 64]);
        end
        EvictReq    = 1'b1;
        VictimWay   = v.way;
        VictimDirty = v.dirty;
        VictimTag   = v.tag;
        VictimSet   = v.set;
        BusWReady   = 1'b0;
        BusBValid   = 1'b0;
        BusBErr     = 1'b0;
        @(posedge clk); @(negedge clk);
        cyc         = 1;
        EvictReq    = 1'b0;
        VictimWay   = 4'($urandom);
        VictimSet   = 7'($urandom);
        VictimTag   = 19'($urandom);
        VictimDirty = 1'($urandom);
        LineRdData  = v.line;
        chk({tag_name, " busy_capture"}, 64'(EvictBusy), 64'd1);
        chk({tag_name, " wvalid_capture"}, 64'(BusWValid), 64'd0);
        responded = 1'b0;
        wcyc      = 0;
        rcyc      = 0;
        forever begin
            @(posedge clk); @(negedge clk);
            cyc++;
            for (int i = 0; i < 16; i++) LineRdData[32*i +: 32] = $urandom;
            if (cyc > 300) begin
                chk({tag_name, " timeout"}, 64'(cyc), 64'd300);
                break;
            end
            if (exp_q.size() > 0) begin
                chk({tag_name, " wvalid"}, 64'(BusWValid), 64'd1);
                chk({tag_name, " wdata"}, BusWData, exp_q[0]);
                chk({tag_name, " wlast"}, 64'(BusWLast), 64'(exp_q.size() == 1));
                chk({tag_name, " adr"}, 64'(BusAdr), 64'(exp_adr));
                chk({tag_name, " done_in_write"}, 64'(EvictDone), 64'd0);
                if (v.rdy_mode == 0)      BusWReady = 1'b1;
                else if (v.rdy_mode == 1) BusWReady = pat[wcyc % 4];
                else                      BusWReady = 1'($urandom_range(0, 1));
                if (BusWReady) void'(exp_q.pop_front());
                wcyc++;
                if (v.spurious) begin
                    EvictReq  = 1'b1;
                    VictimWay = 4'hf;
                    BusBValid = 1'b1;
                    BusBErr   = 1'b1;
                end else begin
                    BusBValid = 1'b0;
                end
            end else if (v.dirty && !responded) begin
                EvictReq  = 1'b0;
                BusWReady = 1'b0;
                chk({tag_name, " wvalid_resp"}, 64'(BusWValid), 64'd0);
                chk({tag_name, " done_in_resp"}, 64'(EvictDone), 64'd0);
                if (rcyc == v.resp_delay) begin
                    BusBValid = 1'b1;
                    BusBErr   = v.err;
                    responded = 1'b1;
                end else begin
                    BusBValid = 1'b0;
                    BusBErr   = 1'($urandom_range(0, 1));
                end
                rcyc++;
            end else begin
                EvictReq  = 1'b0;
                BusWReady = 1'b0;
                BusBValid = 1'b0;
                BusBErr   = 1'b0;
                chk({tag_name, " done"}, 64'(EvictDone), 64'd1);
                chk({tag_name, " err"}, 64'(EvictErr), 64'(v.exp_err));
                chk({tag_name, " clr_way"}, 64'(ClearValidWay), 64'(v.exp_clr));
                chk({tag_name, " clr_set"}, 64'(ClearValidSet), 64'(v.set));
                chk({tag_name, " wvalid_done"}, 64'(BusWValid), 64'd0);
                if (v.exp_lat >= 0) chk({tag_name, " latency"}, 64'(cyc), 64'(v.exp_lat));
                break;
            end
        end
        @(posedge clk); @(negedge clk);
        chk({tag_name, " idle_busy"}, 64'(EvictBusy), 64'd0);
        chk({tag_name, " idle_done"}, 64'(EvictDone), 64'd0);
        chk({tag_name, " idle_clr"}, 64'(ClearValidWay), 64'd0);
    endtask

    vec_t tbl[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        logic [511:0] line;
        reset       = 1'b0;
        EvictReq    = 1'b0;
        VictimWay   = '0;
        VictimDirty = 1'b0;
        VictimTag   = '0;
        VictimSet   = '0;
        LineRdData  = '0;
        BusWReady   = 1'b0;
        BusBValid   = 1'b0;
        BusBErr     = 1'b0;
        #1;
        chk("reset busy", 64'(EvictBusy), 64'd0);
        chk("reset wvalid", 64'(BusWValid), 64'd0);
        chk("reset adr", 64'(BusAdr), 64'd0);
        chk("reset clr", 64'(ClearValidWay), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        //          way     set    tag       d  e  mode dly spur clr    err lat
        tbl[0] = mk(4'b0100, 7'h15, 19'h00001, 0, 0, 0,   0,  0,   4'b0100, 0, 2);
        tbl[1] = mk(4'b0001, 7'h03, 19'h1ABCD, 1, 0, 0,   0,  0,   4'b0001, 0, 11);
        tbl[2] = mk(4'b0010, 7'h7f, 19'h7ffff, 1, 0, 1,   2,  0,   4'b0010, 0, -1);
        tbl[3] = mk(4'b1000, 7'h40, 19'h00001, 1, 1, 0,   0,  0,   4'b0000, 1, 11);
        tbl[4] = mk(4'b0100, 7'h22, 19'h12345, 1, 0, 0,   1,  1,   4'b0100, 0, 12);
        tbl[5] = mk(4'b0000, 7'h01, 19'h00010, 0, 0, 0,   0,  0,   4'b0000, 0, 2);
        tbl[6] = mk(4'b0110, 7'h55, 19'h00020, 0, 0, 0,   0,  0,   4'b0110, 0, 2);
        for (int i = 0; i < 7; i++) run_evict(tbl[i], $sformatf("tbl%0d", i));

        // Reset in the middle of a burst, just after beat 3 is accepted.
        for (int i = 0; i < 16; i++) line[32*i +: 32] = $urandom;
        EvictReq = 1'b1; VictimWay = 4'b0010; VictimDirty = 1'b1;
        VictimTag = 19'h0F0F0; VictimSet = 7'h11;
        @(posedge clk); @(negedge clk);
        EvictReq = 1'b0; LineRdData = line; BusWReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("rst_burst beat%0d", k), BusWData, line[64*k +: 64]);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid busy", 64'(EvictBusy), 64'd0);
        chk("rst_mid wvalid", 64'(BusWValid), 64'd0);
        chk("rst_mid wdata", BusWData, 64'd0);
        chk("rst_mid wlast", 64'(BusWLast), 64'd0);
        chk("rst_mid adr", 64'(BusAdr), 64'd0);
        chk("rst_mid done", 64'(EvictDone), 64'd0);
        BusWReady = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_evict(mk(4'b1000, 7'h0a, 19'h00abc, 0, 0, 0, 0, 0, 4'b1000, 0, 2), "post_rst_clean");
        run_evict(mk(4'b0001, 7'h0b, 19'h00def, 1, 0, 0, 0, 0, 4'b0001, 0, 11), "post_rst_dirty");

        // Randomized evictions.
        for (int n = 0; n < 24; n++) begin
            v.way = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            v.set = 7'($urandom);
            v.tag = 19'($urandom);
            v.dirty = 1'($urandom_range(0, 1));
            v.err = ($urandom_range(0, 3) == 0);
            v.rdy_mode = $urandom_range(0, 2);
            v.resp_delay = $urandom_range(0, 3);
            v.spurious = 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) v.line[32*i +: 32] = $urandom;
            v.exp_err = v.dirty && v.err;
            v.exp_clr = v.exp_err ? 4'b0000 : v.way;
            if (!v.dirty)                v.exp_lat = 2;
            else if (v.rdy_mode == 0)    v.exp_lat = 11 + v.resp_delay;
            else                         v.exp_lat = -1;
            run_evict(v, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
